// File: rtl/fb_arb_pkg.sv
// Shared types and the round-robin pick used by the framebuffer memory arbiter.
package fb_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Largest supported requester count; owner indices are sized for it.
    localparam int MAX_NREQ = 4;
    localparam int IDX_W    = 2;

    typedef logic [IDX_W-1:0] req_idx_t;

    // Returns the first asserted request strictly after 'last', wrapping modulo
    // nreq. Scanning from the far end and overwriting leaves the nearest hit.
    function automatic req_idx_t rr_next(
        input logic [MAX_NREQ-1:0] req,
        input req_idx_t            last,
        input int                  nreq
    );
        req_idx_t pick;
        int       idx;
        pick = last;
        for (int k = MAX_NREQ; k >= 1; k--) begin
            if (k <= nreq) begin
                idx = (int'(last) + k) % nreq;
                if (req[idx[IDX_W-1:0]]) begin
                    pick = idx[IDX_W-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fb_mem_arbiter.sv
// Framebuffer memory port arbiter: round-robin between NREQ single-beat
// Wishbone-style requesters with a per-grant hold limit. Requester 0 is the
// VGA reader, the rest are pixel writers.
module fb_mem_arbiter
    import fb_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ-1:0]        we_i,
    input  logic [NREQ*AW-1:0]     adr_i,
    input  logic [NREQ*DW-1:0]     dat_i,
    input  logic [NREQ*DW/8-1:0]   sel_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic [NREQ-1:0]        ack_o,
    output logic [DW-1:0]          dat_o,
    output logic                   m_cyc_o,
    output logic                   m_stb_o,
    output logic                   m_we_o,
    output logic [AW-1:0]          m_adr_o,
    output logic [DW-1:0]          m_dat_o,
    output logic [DW/8-1:0]        m_sel_o,
    input  logic                   m_ack_i,
    input  logic [DW-1:0]          m_dat_i
);

    localparam int SW = DW / 8;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t          state_reg, state_next;
    req_idx_t            owner_reg, owner_next;
    req_idx_t            last_reg, last_next;
    logic [HW-1:0]       hold_cnt_reg, hold_cnt_next;
    logic [NREQ-1:0]     gnt_reg, gnt_next;

    logic [MAX_NREQ-1:0] req_pad;
    logic                owner_req;
    logic                others_wait;
    logic                beat_ack;

    logic [AW-1:0]       adr_masked [NREQ];
    logic [DW-1:0]       dat_masked [NREQ];
    logic [SW-1:0]       sel_masked [NREQ];

    assign req_pad = MAX_NREQ'(req_i);

    // Per-requester slices gated by the registered one-hot grant, so the
    // slave-side mux below is a plain OR of at most one live lane.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign adr_masked[gi] = gnt_reg[gi] ? adr_i[gi*AW +: AW] : '0;
            assign dat_masked[gi] = gnt_reg[gi] ? dat_i[gi*DW +: DW] : '0;
            assign sel_masked[gi] = gnt_reg[gi] ? sel_i[gi*SW +: SW] : '0;
        end
    endgenerate

    // Combinational request mux from the current owner to the slave port.
    always_comb begin
        m_adr_o = '0;
        m_dat_o = '0;
        m_sel_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            m_adr_o = m_adr_o | adr_masked[i];
            m_dat_o = m_dat_o | dat_masked[i];
            m_sel_o = m_sel_o | sel_masked[i];
        end
    end

    // Owner status: its pending beat, and whether anybody else is queued.
    assign owner_req   = |(req_i & gnt_reg);
    assign others_wait = |(req_i & ~gnt_reg);
    assign m_we_o      = |(we_i & gnt_reg);

    // The slave sees a cycle for the whole grant; stb follows the owner's
    // request so it is never dropped while a beat is outstanding.
    assign m_cyc_o  = (state_reg == GRANT);
    assign m_stb_o  = m_cyc_o & owner_req;
    assign beat_ack = m_stb_o & m_ack_i;

    assign gnt_o = gnt_reg;
    assign ack_o = beat_ack ? gnt_reg : '0;
    assign dat_o = m_dat_i;

    // State, owner, round-robin pointer, hold counter and grant register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            last_reg     <= req_idx_t'(NREQ - 1);
            hold_cnt_reg <= '0;
            gnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            last_reg     <= last_next;
            hold_cnt_reg <= hold_cnt_next;
            gnt_reg      <= gnt_next;
        end
    end

    // Next-state: arbitrate from IDLE, release the port when the owner is
    // done or has used its hold budget while someone else waits.
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        last_next     = last_reg;
        hold_cnt_next = hold_cnt_reg;
        gnt_next      = '0;

        case (state_reg)
            IDLE: begin
                if (|req_i) begin
                    state_next    = GRANT;
                    owner_next    = rr_next(req_pad, last_reg, NREQ);
                    hold_cnt_next = '0;
                end
            end
            GRANT: begin
                if (beat_ack && (hold_cnt_reg != HOLD_LAST)) begin
                    hold_cnt_next = hold_cnt_reg + HW'(1);
                end
                if (!owner_req) begin
                    state_next    = IDLE;
                    last_next     = owner_reg;
                    hold_cnt_next = '0;
                end else if (beat_ack && (hold_cnt_reg == HOLD_LAST) && others_wait) begin
                    state_next    = IDLE;
                    last_next     = owner_reg;
                    hold_cnt_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        for (int i = 0; i < NREQ; i++) begin
            gnt_next[i] = (state_next == GRANT) && (owner_next == req_idx_t'(i));
        end
    end

    // Structural invariants of the grant/ack outputs.
    a_gnt_onehot: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        $onehot0(gnt_o));
    a_ack_owner: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        (|ack_o) |-> ((ack_o & gnt_o) == ack_o));

endmodule
